exc_check_requester: RTL
========================

Name: exc_check_requester

Overview:
- Initiator side of the exception-check handshake (Data / Data_valid / ACK / Exc).
- Buffers 32-bit single-precision results from the FPU datapath in a small FIFO.
- Presents results to the exception checker one at a time and waits for its ACK pulse.
- Captures the returned exception code and emits {result, code} on a valid/ready output; a timeout guards against a stalled checker.

Parameters:
- DEPTH, 4, input FIFO entries; power of two, >= 2
- TIMEOUT, 15, max cycles in REQ without ACK before abort; >= 2

Ports:
- CLK  input  1  clock, all logic on rising edge
- RST  input  1  reset; synchronous, active-high
- In_data  input  32  IEEE-754 single result from datapath
- In_valid  input  1  In_data valid
- In_ready  output  1  FIFO can accept; = !full
- Data  output  32  operand to checker
- Data_valid  output  1  request to checker
- ACK  input  1  checker acknowledge; single-cycle pulse
- Exc  input  3  checker code; meaningful only in the ACK cycle
- Out_data  output  32  checked result
- Out_exc  output  3  000 normal, 011 infinity, 100 NaN, 111 timeout
- Out_valid  output  1  Out_data/Out_exc valid
- Out_ready  input  1  downstream accepts
- Timeout_err  output  1  sticky, set on any timeout

Behaviour:
- Reset (RST=1 at an edge) clears:
  - FIFO pointers and count (In_ready=1 from next cycle)
  - FSM to IDLE; Data_valid=0, Data=0
  - Out_valid=0, Out_data=0, Out_exc=0
  - Timeout_err=0, timeout counter=0
- Reset mid-transaction aborts the transaction; no result is emitted.
- FIFO:
  - Push on In_valid & In_ready.
  - Pop when the FSM leaves IDLE for REQ.
  - Push and pop in the same cycle: count unchanged. When full, In_ready=0, so no push occurs even if a pop happens that cycle.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is $clog2(DEPTH+1) bits.
- FSM states:
  - IDLE:
    - Go to REQ when FIFO not empty AND (!Out_valid OR Out_ready).
    - On that edge: load Data from FIFO head, pop, set Data_valid=1, clear timeout counter.
  - REQ:
    - Data_valid=1 and Data held stable.
    - ACK=1 in this cycle: capture Out_data=Data and Out_exc=qualified code; set Out_valid; go to GAP.
    - Else increment the counter. When counter==TIMEOUT-1 with no ACK: Out_data=Data, Out_exc=111, Out_valid=1, set Timeout_err, go to GAP.
  - GAP:
    - Data_valid=0 for exactly one cycle; always go to IDLE.
    - This guarantees the checker returns to its compute state before the next request.
- Exc qualification:
  - Out_exc=Exc only if Data[30:23]==8'hFF and Exc is 011 or 100; otherwise 000.
  - This makes stale codes on normal operands harmless.
- ACK in IDLE or GAP is ignored; Exc is never sampled outside REQ.
- Output register:
  - Out_valid is cleared on Out_valid & Out_ready unless a new capture happens the same edge; a new capture wins.
  - Out_data/Out_exc are stable while Out_valid & !Out_ready.
- Latency with a combinational same-cycle ACK:
  - In_data accepted at edge t.
  - Data_valid=1 during cycle t+1.
  - Out_valid=1 after edge t+2.
  - Back-to-back requests are spaced 3 cycles (REQ, GAP, IDLE).
- Timeout_err stays 1 until RST.

Test Plan:
- Reset, then push 0x3F800000 with ACK returned in the REQ cycle and Exc=000 -> Data_valid high one cycle; Out_valid after 2 cycles with Out_data=0x3F800000, Out_exc=000.
- Push 0x7F800000, ACK with Exc=011; then push 0x7FC00000, ACK with Exc=100 -> outputs in order: (0x7F800000,011), (0x7FC00000,100); Data_valid low at least one cycle between requests.
- Push 0x40000000, checker returns stale Exc=011 with ACK -> Out_exc=000.
- Hold Out_ready=0 and push 5 values with DEPTH=4 -> 4 values remain in the FIFO, 1 is held in the output register, In_ready=0 and no further request is issued. Then raise Out_ready -> all 5 values emerge in order with no loss.
- Never assert ACK -> Data_valid high for exactly 15 cycles, then Out_exc=111, Timeout_err=1 (sticky); the next FIFO entry is still processed normally.
- Assert RST during REQ with 2 entries queued -> next cycle Data_valid=0, Out_valid=0, In_ready=1, Timeout_err=0; a late ACK arriving in IDLE produces no output.

Source files
------------

// File: rtl/exc_check_requester.sv
// Initiator side of the exception-check handshake: queues FPU results, issues one
// request at a time to the checker, and registers {result, qualified code} for downstream.
module exc_check_requester #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] In_data,
  input  logic        In_valid,
  output logic        In_ready,
  output logic [31:0] Data,
  output logic        Data_valid,
  input  logic        ACK,
  input  logic [2:0]  Exc,
  output logic [31:0] Out_data,
  output logic [2:0]  Out_exc,
  output logic        Out_valid,
  input  logic        Out_ready,
  output logic        Timeout_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   out_data_q, out_data_d;
  logic [2:0]    out_exc_q, out_exc_d;
  logic          out_valid_q, out_valid_d;
  logic          err_q, err_d;
  logic          push, pop, capture;
  logic [2:0]    cap_exc, qual_exc;

  assign In_ready    = (count_q != FULL_CNT);
  assign push        = In_valid && In_ready;
  assign Data        = data_q;
  assign Data_valid  = (state_q == REQ);
  assign Out_data    = out_data_q;
  assign Out_exc     = out_exc_q;
  assign Out_valid   = out_valid_q;
  assign Timeout_err = err_q;

  // Codes only pass through for an all-ones exponent; stale codes on normal operands read as 000.
  assign qual_exc = ((data_q[30:23] == 8'hFF) && ((Exc == 3'b011) || (Exc == 3'b100))) ? Exc : 3'b000;

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    data_d      = data_q;
    err_d       = err_q;
    pop         = 1'b0;
    capture     = 1'b0;
    cap_exc     = 3'b000;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && (!out_valid_q || Out_ready)) begin
          state_d   = REQ;
          pop       = 1'b1;
          data_d    = mem_q[rd_ptr_q];
          tmo_cnt_d = '0;
        end
      end
      REQ: begin
        if (ACK) begin
          capture = 1'b1;
          cap_exc = qual_exc;
          state_d = GAP;
        end else if (tmo_cnt_q == TO_LAST) begin
          capture = 1'b1;
          cap_exc = 3'b111;
          err_d   = 1'b1;
          state_d = GAP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_exc_d   = out_exc_q;
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = data_q;
      out_exc_d   = cap_exc;
    end else if (out_valid_q && Out_ready) begin
      out_valid_d = 1'b0;
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= In_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tmo_cnt_q   <= '0;
      data_q      <= '0;
      out_data_q  <= '0;
      out_exc_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tmo_cnt_q   <= tmo_cnt_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      out_exc_q   <= out_exc_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

endmodule
